matmul_output_collector: RTL and testbench



---
 rtl/matmul_output_collector.sv | 155 +++++++++++++++
 tb/tb_matmul_output_collector.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_output_collector.sv
// matmul_output_collector
//
// Assembles the per-column output stream of the systolic matmul FSM into a
// ROWS x COLS result matrix. Each column keeps its own write row counter
// (wcount) and hold-phase counter (phase). A source value held for
// HOLD_CYCLES consecutive valid cycles is captured exactly once.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse: clear matrix/counters/overflow, enter CAPTURE
//   col_valid      per-column valid
//   col_data       column c at [c*WORD_SIZE +: WORD_SIZE]
//   rd_row, rd_col random-access read address
//   rd_data        registered element [rd_row][rd_col] (0 when out of range)
//   output_matrix  element [r][c] at [(r*COLS+c)*WORD_SIZE +: WORD_SIZE]
//   busy / done    CAPTURE / DONE state decodes
//   overflow       sticky: valid element for a full column or outside CAPTURE
module matmul_output_collector #(
  parameter int WORD_SIZE   = 16,
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COLS-1:0]                col_valid,
  input  logic [COLS*WORD_SIZE-1:0]      col_data,
  input  logic [RW-1:0]                  rd_row,
  input  logic [CLW-1:0]                 rd_col,
  output logic [WORD_SIZE-1:0]           rd_data,
  output logic [ROWS*COLS*WORD_SIZE-1:0] output_matrix,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int PW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] FULL    = CW'(ROWS);
  localparam logic [PW-1:0] PH_LAST = PW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] mat_q    [ROWS][COLS];
  logic [WORD_SIZE-1:0] mat_d    [ROWS][COLS];
  logic [CW-1:0]        wcount_q [COLS];
  logic [CW-1:0]        wcount_d [COLS];
  logic [PW-1:0]        phase_q  [COLS];
  logic [PW-1:0]        phase_d  [COLS];
  logic                 overflow_q, overflow_d;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 all_full;

  // Next-state, capture and overflow logic.
  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    wcount_d   = wcount_q;
    phase_d    = phase_q;
    overflow_d = overflow_q;
    all_full   = 1'b1;

    if (start) begin
      // start wins over any same-cycle valid and over the DONE transition
      state_d    = S_CAPTURE;
      overflow_d = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mat_d[r][c] = '0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        wcount_d[c] = '0;
        phase_d[c]  = '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (col_valid[c]) begin
          // Only the first cycle of a hold window carries a new element.
          if (phase_q[c] == '0) begin
            if (state_q == S_CAPTURE && wcount_q[c] != FULL) begin
              mat_d[wcount_q[c][RW-1:0]][c] = col_data[c*WORD_SIZE +: WORD_SIZE];
              wcount_d[c] = wcount_q[c] + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
          phase_d[c] = (phase_q[c] == PH_LAST) ? '0 : phase_q[c] + PW'(1);
        end else begin
          // A gap restarts the hold window.
          phase_d[c] = '0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (wcount_d[c] != FULL) all_full = 1'b0;
      end
      // DONE on the same edge that writes the last element.
      if (state_q == S_CAPTURE && all_full) state_d = S_DONE;
    end
  end

  // Registered read port; sees the matrix as of the previous edge.
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_row) < ROWS && int'(rd_col) < COLS) begin
      rd_data_d = mat_q[rd_row][rd_col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mat_q[r][c] <= '0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        wcount_q[c] <= '0;
        phase_q[c]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      mat_q      <= mat_d;
      wcount_q   <= wcount_d;
      phase_q    <= phase_d;
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
        assign output_matrix[(gi*COLS+gj)*WORD_SIZE +: WORD_SIZE] = mat_q[gi][gj];
      end
    end
  endgenerate

  assign rd_data  = rd_data_q;
  assign busy     = (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_matmul_output_collector.sv
// Testbench for matmul_output_collector. Instance A is 4x4 with HOLD=2 and is
// checked every cycle against a matrix-level reference model; instance B is
// 2x3 with HOLD=1 and is checked with directed expectations.
module tb_matmul_output_collector;

  localparam int W  = 16;
  localparam int RA = 4;
  localparam int CA = 4;
  localparam int HA = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A
  logic              start_a;
  logic [CA-1:0]     valid_a;
  logic [CA*W-1:0]   data_a;
  logic [1:0]        rd_row_a, rd_col_a;
  logic [W-1:0]      rd_data_a;
  logic [RA*CA*W-1:0] mat_a;
  logic              busy_a, done_a, ovf_a;

  // instance B
  logic              start_b;
  logic [2:0]        valid_b;
  logic [3*W-1:0]    data_b;
  logic [0:0]        rd_row_b;
  logic [1:0]        rd_col_b;
  logic [W-1:0]      rd_data_b;
  logic [2*3*W-1:0]  mat_b;
  logic              busy_b, done_b, ovf_b;

  matmul_output_collector #(.WORD_SIZE(W), .ROWS(RA), .COLS(CA), .HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .col_valid(valid_a), .col_data(data_a),
    .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_data(rd_data_a), .output_matrix(mat_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a));

  matmul_output_collector #(.WORD_SIZE(W), .ROWS(2), .COLS(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .col_valid(valid_b), .col_data(data_b),
    .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_data(rd_data_b), .output_matrix(mat_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for A: a matrix, a fill count per column, and the length
  // of the current run of consecutive valid cycles per column. A run position
  // that is a multiple of HOLD is a new element.
  logic [W-1:0] m_mat [RA][CA];
  int           m_cnt [CA];
  int           m_run [CA];
  bit           m_ovf;
  int           m_st;   // 0 idle, 1 capturing, 2 complete
  logic [W-1:0] m_rd;

  task automatic model_clear();
    for (int r = 0; r < RA; r++)
      for (int c = 0; c < CA; c++) m_mat[r][c] = '0;
    for (int c = 0; c < CA; c++) begin
      m_cnt[c] = 0;
      m_run[c] = 0;
    end
    m_ovf = 1'b0;
  endtask

  // Advance one clock edge, updating the model with the inputs driven
  // before the edge; returns 1 time unit after the edge.
  task automatic step();
    bit full;
    @(posedge clk);
    m_rd = m_mat[rd_row_a][rd_col_a];
    if (rst) begin
      model_clear();
      m_rd = '0;
      m_st = 0;
    end else if (start_a) begin
      model_clear();
      m_st = 1;
    end else begin
      for (int c = 0; c < CA; c++) begin
        if (valid_a[c]) begin
          if (m_run[c] % HA == 0) begin
            if (m_st == 1 && m_cnt[c] < RA) begin
              m_mat[m_cnt[c]][c] = data_a[c*W +: W];
              m_cnt[c]++;
            end else begin
              m_ovf = 1'b1;
            end
          end
          m_run[c]++;
        end else begin
          m_run[c] = 0;
        end
      end
      if (m_st == 1) begin
        full = 1'b1;
        for (int c = 0; c < CA; c++) if (m_cnt[c] < RA) full = 1'b0;
        if (full) m_st = 2;
      end
    end
    #1;
  endtask

  function automatic logic [RA*CA*W-1:0] model_flat();
    logic [RA*CA*W-1:0] v;
    for (int r = 0; r < RA; r++)
      for (int c = 0; c < CA; c++) v[(r*CA+c)*W +: W] = m_mat[r][c];
    return v;
  endfunction

  function automatic logic [RA*CA*W+W+2:0] exp_vec();
    return {model_flat(), m_rd, (m_st == 1), (m_st == 2), m_ovf};
  endfunction

  function automatic logic [RA*CA*W+W+2:0] got_vec();
    return {mat_a, rd_data_a, busy_a, done_a, ovf_a};
  endfunction

  function automatic logic [RA*CA*W-1:0] nominal_matrix();
    logic [RA*CA*W-1:0] v;
    for (int r = 0; r < RA; r++)
      for (int c = 0; c < CA; c++) v[(r*CA+c)*W +: W] = 16'(16'h0100 * r + c);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    if ({mat_a, rd_data_a, busy_a, done_a, ovf_a} !== '0) begin
      n_bad++; $display("FAIL reset_a got=%h required=0", {mat_a, rd_data_a, busy_a, done_a, ovf_a});
    end
    n_cmp++;
    if ({mat_b, rd_data_b, busy_b, done_b, ovf_b} !== '0) begin
      n_bad++; $display("FAIL reset_b got=%h required=0", {mat_b, rd_data_b, busy_b, done_b, ovf_b});
    end
    n_cmp++;
    rst = 1'b0;
    step();
    $display("reset: A busy=%0b done=%0b ovf=%0b", busy_a, done_a, ovf_a);
  endtask

  task automatic test_nominal();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (busy_a !== 1'b1 || mat_a !== '0) begin
      n_bad++; $display("FAIL nominal_start busy=%b required 1, matrix nonzero=%b", busy_a, |mat_a);
    end
    n_cmp++;
    for (int t = 0; t < 2*RA + CA - 1; t++) begin
      for (int c = 0; c < CA; c++) begin
        valid_a[c] = (t >= c && t < c + 2*RA);
        data_a[c*W +: W] = valid_a[c] ? 16'(16'h0100 * ((t - c) / 2) + c) : 16'($urandom);
      end
      step();
      if (got_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL nominal_cycle t=%0d got=%h required=%h", t, got_vec(), exp_vec());
      end
      n_cmp++;
      // last element (row 3 of column 3) is written on cycle 9
      if (done_a !== (t >= 9)) begin
        n_bad++; $display("FAIL nominal_done t=%0d got=%b required=%b", t, done_a, (t >= 9));
      end
      n_cmp++;
    end
    valid_a = '0;
    if (mat_a !== nominal_matrix() || ovf_a !== 1'b0) begin
      n_bad++; $display("FAIL nominal_matrix got=%h ovf=%b required=%h ovf=0", mat_a, ovf_a, nominal_matrix());
    end
    n_cmp++;
    rd_row_a = 2'd3;
    rd_col_a = 2'd2;
    step();
    if (rd_data_a !== 16'h0302) begin
      n_bad++; $display("FAIL nominal_readback got=%h required=0302", rd_data_a);
    end
    n_cmp++;
    $display("nominal: matrix captured, done=%0b rd[3][2]=%h", done_a, rd_data_a);
  endtask

  task automatic test_overflow();
    valid_a = 4'b0001;
    data_a  = {4{16'hDEAD}};
    step();
    step();
    valid_a = '0;
    step();
    if (got_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL overflow_model got=%h required=%h", got_vec(), exp_vec());
    end
    n_cmp++;
    if (ovf_a !== 1'b1 || done_a !== 1'b1 || mat_a !== nominal_matrix()) begin
      n_bad++; $display("FAIL overflow_after_done ovf=%b done=%b required 1/1 matrix_ok=%b", ovf_a, done_a, mat_a === nominal_matrix());
    end
    n_cmp++;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    if (ovf_a !== 1'b0 || mat_a !== '0 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL overflow_cleared ovf=%b busy=%b required 0/1, matrix nonzero=%b", ovf_a, busy_a, |mat_a);
    end
    n_cmp++;
    $display("overflow: set after done, cleared by start");
  endtask

  task automatic test_gap();
    bit [3:0] pat [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int t = 0; t < 5; t++) begin
      valid_a = pat[t];
      data_a  = {4{(t == 0) ? 16'h00AA : 16'h00BB}};
      step();
      if (got_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL gap_cycle t=%0d got=%h required=%h", t, got_vec(), exp_vec());
      end
      n_cmp++;
    end
    valid_a = '0;
    if (mat_a[(0*CA+1)*W +: W] !== 16'h00AA || mat_a[(1*CA+1)*W +: W] !== 16'h00BB
        || mat_a[(2*CA+1)*W +: W] !== 16'h0000) begin
      n_bad++; $display("FAIL gap_rows got=%h/%h/%h required=00aa/00bb/0000",
        mat_a[(0*CA+1)*W +: W], mat_a[(1*CA+1)*W +: W], mat_a[(2*CA+1)*W +: W]);
    end
    n_cmp++;
    $display("gap: col1 rows0/1 = %h/%h", mat_a[(0*CA+1)*W +: W], mat_a[(1*CA+1)*W +: W]);
  endtask

  task automatic test_restart();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    // col0 valid 4 cycles (2 elements) + col2 valid 6 cycles (3 elements)
    for (int t = 0; t < 6; t++) begin
      valid_a = {1'b0, (t < 6), 1'b0, (t < 4)};
      data_a  = {$urandom, $urandom};
      step();
    end
    if (got_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL restart_five got=%h required=%h", got_vec(), exp_vec());
    end
    n_cmp++;
    start_a = 1'b1;
    valid_a = 4'b1111;
    data_a  = {$urandom, $urandom};
    step();
    start_a = 1'b0;
    if (mat_a !== '0 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL restart_zeroed busy=%b required 1, matrix=%h required 0", busy_a, mat_a);
    end
    n_cmp++;
    valid_a = 4'b1000;
    data_a  = {16'h1234, 48'h0};
    step();
    valid_a = '0;
    if (mat_a !== {16'h1234, {(RA*CA-1)*W{1'b0}}} >> ((RA*CA-1-3)*W)) begin
      n_bad++; $display("FAIL restart_row0 got=%h required only [0][3]=1234", mat_a);
    end
    n_cmp++;
    if (got_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL restart_model got=%h required=%h", got_vec(), exp_vec());
    end
    n_cmp++;
    $display("restart: matrix cleared, [0][3]=%h", mat_a[3*W +: W]);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    if ({mat_a, rd_data_a, busy_a, done_a, ovf_a} !== '0) begin
      n_bad++; $display("FAIL reset_mid got=%h required=0", {mat_a, rd_data_a, busy_a, done_a, ovf_a});
    end
    n_cmp++;
    for (int t = 0; t < 3; t++) begin
      valid_a = 4'($urandom_range(1, 15));
      data_a  = {$urandom, $urandom};
      step();
      if (mat_a !== '0 || busy_a !== 1'b0 || got_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_mid_ignored t=%0d got=%h required=%h", t, got_vec(), exp_vec());
      end
      n_cmp++;
    end
    valid_a = '0;
    step();
    $display("reset_mid: idle, matrix zero, ovf=%0b", ovf_a);
  endtask

  task automatic test_hold1();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int t = 0; t < 2; t++) begin
      valid_b = 3'b111;
      for (int c = 0; c < 3; c++) data_b[c*W +: W] = 16'(16'h0010 * (t + 1) + c);
      step();
      if (done_b !== (t == 1) || busy_b !== (t == 0)) begin
        n_bad++; $display("FAIL hold1_state t=%0d done=%b busy=%b required %b/%b", t, done_b, busy_b, (t == 1), (t == 0));
      end
      n_cmp++;
    end
    valid_b = '0;
    if (mat_b !== {16'h0022, 16'h0021, 16'h0020, 16'h0012, 16'h0011, 16'h0010} || ovf_b !== 1'b0) begin
      n_bad++; $display("FAIL hold1_matrix got=%h ovf=%b", mat_b, ovf_b);
    end
    n_cmp++;
    rd_row_b = 1'b1;
    rd_col_b = 2'd2;
    step();
    if (rd_data_b !== 16'h0022) begin
      n_bad++; $display("FAIL hold1_read got=%h required=0022", rd_data_b);
    end
    n_cmp++;
    rd_col_b = 2'd3;
    step();
    if (rd_data_b !== 16'h0000) begin
      n_bad++; $display("FAIL hold1_read_oob got=%h required=0000", rd_data_b);
    end
    n_cmp++;
    $display("hold1: 2x3 captured, done=%0b", done_b);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int t = 0; t < 50; t++) begin
        for (int c = 0; c < CA; c++) valid_a[c] = ($urandom_range(0, 9) < 6);
        data_a   = {$urandom, $urandom};
        rd_row_a = 2'($urandom);
        rd_col_a = 2'($urandom);
        start_a  = ($urandom_range(0, 79) == 0);
        step();
        if (got_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL random f=%0d t=%0d got=%h required=%h", f, t, got_vec(), exp_vec());
        end
        n_cmp++;
      end
      start_a = 1'b0;
      valid_a = '0;
      $display("random frame %0d: done=%0b ovf=%0b", f, done_a, ovf_a);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; valid_a = '0; data_a = '0; rd_row_a = '0; rd_col_a = '0;
    start_b = 1'b0; valid_b = '0; data_b = '0; rd_row_b = '0; rd_col_b = '0;
    model_clear();
    m_st = 0;
    m_rd = '0;
    test_reset();
    test_nominal();
    test_overflow();
    test_gap();
    test_restart();
    test_reset_mid();
    test_hold1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
